// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline stage status in, stall/flush controls and event counters out
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 6,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              ex_valid;
    logic              ex_RegWrt;
    logic [REG_AW-1:0] ex_rd;
    logic              wb_valid;
    logic              wb_RegWrt;
    logic [REG_AW-1:0] wb_rd;
    logic              controlA;
    logic              controlB;
    logic              clr_cnt;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              exwb_flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              hazard_err;
    modport master (
        output id_valid, id_rs, id_rt, ex_valid, ex_RegWrt, ex_rd, wb_valid, wb_RegWrt, wb_rd,
               controlA, controlB, clr_cnt,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, exwb_flush, stall_cnt, flush_cnt, hazard_err
    );
    modport slave (
        input  id_valid, id_rs, id_rt, ex_valid, ex_RegWrt, ex_rd, wb_valid, wb_RegWrt, wb_rd,
               controlA, controlB, clr_cnt,
        output pc_en, ifid_en, ifid_flush, idex_bubble, exwb_flush, stall_cnt, flush_cnt, hazard_err
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW stall and redirect squash sequencing for a 4-stage IF/ID/EX/WB pipe
module pipeline_hazard_ctrl #(
    parameter int SHADOW    = 2,
    parameter int MAX_STALL = 4
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
    localparam logic [2:0] SH_INIT = 3'(SHADOW - 1);
    localparam logic [3:0] SC_MAX  = 4'(MAX_STALL);
    state_t     r_state, w_next;
    logic [2:0] r_sh, w_sh;
    logic [3:0] r_sc, w_sc;
    logic       w_redirect, w_hit_ex, w_hit_wb, w_hazard, w_release, w_flush, w_stall;
    always_comb begin
        w_redirect = bus.controlA | bus.controlB;
        w_hit_ex   = bus.ex_valid & bus.ex_RegWrt & ((bus.id_rs == bus.ex_rd) | (bus.id_rt == bus.ex_rd));
        w_hit_wb   = bus.wb_valid & bus.wb_RegWrt & ((bus.id_rs == bus.wb_rd) | (bus.id_rt == bus.wb_rd));
        w_hazard   = bus.id_valid & (w_hit_ex | w_hit_wb);
        // watchdog: a stall held MAX_STALL cycles is let go for one cycle
        w_release  = !w_redirect && r_state == STALL && w_hazard && r_sc >= SC_MAX;
        w_flush    = w_redirect || r_state == FLUSH;
        w_stall    = !w_flush && w_hazard && !w_release;
        w_next     = r_state;
        w_sh       = r_sh;
        w_sc       = r_sc;
        if (w_redirect) begin
            w_next = SHADOW == 1 ? RUN : FLUSH;
            w_sh   = SH_INIT;
        end else begin
            case (r_state)
                RUN: if (w_hazard) begin
                    w_next = STALL;
                    w_sc   = 4'd1;
                end
                STALL: if (!w_hazard || w_release) w_next = RUN;
                       else w_sc = r_sc + 4'd1;
                FLUSH: if (r_sh <= 3'd1) w_next = RUN;
                       else w_sh = r_sh - 3'd1;
                default: w_next = RUN;
            endcase
        end
        bus.pc_en       = !reset && !w_stall;
        bus.ifid_en     = !reset && !w_stall;
        bus.ifid_flush  = reset || w_flush;
        bus.idex_bubble = reset || w_flush || w_stall;
        bus.exwb_flush  = reset;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= RUN;
            r_sh           <= '0;
            r_sc           <= '0;
            bus.stall_cnt  <= '0;
            bus.flush_cnt  <= '0;
            bus.hazard_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sh    <= w_sh;
            r_sc    <= w_sc;
            if (bus.clr_cnt) bus.stall_cnt <= '0;
            else if (w_stall && bus.stall_cnt != '1) bus.stall_cnt <= bus.stall_cnt + 1'b1;
            if (bus.clr_cnt) bus.flush_cnt <= '0;
            else if (w_redirect && bus.flush_cnt != '1) bus.flush_cnt <= bus.flush_cnt + 1'b1;
            bus.hazard_err <= w_release | (bus.hazard_err & !bus.clr_cnt);
        end
    end
endmodule
